// File: rtl/apb_rambus_bridge.sv
// apb_rambus_bridge: APB3 slave that forwards each transfer to the RamBus and waits for an ack or a timeout.
//   clk, nRst                       rising-edge clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA APB3 request; PRDATA/PREADY/PSLVERR APB3 response
//   RamBusnCs/WrnRd/Latch/Address/DataIn  downstream request; RamBusDataOut/RamBusAck downstream response
//   TimeoutCount                    saturating count of transfers that ended in a timeout
module apb_rambus_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [13:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        RamBusnCs,
  output logic        RamBusWrnRd,
  output logic        RamBusLatch,
  output logic [13:0] RamBusAddress,
  output logic [31:0] RamBusDataIn,
  input  logic [31:0] RamBusDataOut,
  input  logic        RamBusAck,
  output logic [15:0] TimeoutCount
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t        state, state_n;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   rdata_q;
  logic          err_q, wr_q;
  logic          setup, ack_hit, tmo_hit;
  // An ack is checked before the timeout so it wins when both land on the same cycle;
  // the timeout fires on the cycle whose missing ack would bring the count to TIMEOUT_CYCLES.
  always_comb begin
    state_n = state;
    setup   = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE: if (PSEL && !PENABLE) begin
        setup   = 1'b1;
        state_n = REQ;
      end
      REQ: if (!PSEL) state_n = IDLE;
      else if (RamBusAck) begin
        ack_hit = 1'b1;
        state_n = RESP;
      end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit = 1'b1;
        state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      RamBusAddress <= '0;
      RamBusDataIn  <= '0;
      wr_q          <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      TimeoutCount  <= '0;
    end else begin
      state <= state_n;
      if (setup) begin
        RamBusAddress <= PADDR;
        RamBusDataIn  <= PWDATA;
        wr_q          <= PWRITE;
        wait_cnt      <= '0;
      end else if (state == REQ && !RamBusAck) wait_cnt <= wait_cnt + CW'(1);
      if (ack_hit) begin
        if (!wr_q) rdata_q <= RamBusDataOut;
        err_q <= 1'b0;
      end
      if (tmo_hit) begin
        rdata_q <= ERR_DATA;
        err_q   <= 1'b1;
        if (TimeoutCount != 16'hFFFF) TimeoutCount <= TimeoutCount + 16'd1;
      end
    end
  end
  assign RamBusnCs   = state == REQ;
  assign RamBusLatch = state == REQ;
  assign RamBusWrnRd = state == REQ && wr_q;
  assign PREADY      = state == RESP;
  assign PSLVERR     = state == RESP && err_q;
  assign PRDATA      = state == RESP ? rdata_q : 32'h0;
endmodule

// File: tb/tb_apb_rambus_bridge.sv
// tb_apb_rambus_bridge: randomized self-checking bench for apb_rambus_bridge against a transfer-level model.
module tb_apb_rambus_bridge;
  localparam int          TO  = 255;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;
  logic        clk = 1'b0, nRst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [13:0] PADDR = '0;
  logic [31:0] PWDATA = '0, RamBusDataOut = '0;
  logic        RamBusAck = 1'b0;
  logic [31:0] PRDATA, RamBusDataIn;
  logic        PREADY, PSLVERR, RamBusnCs, RamBusWrnRd, RamBusLatch;
  logic [13:0] RamBusAddress;
  logic [15:0] TimeoutCount;
  int          checks = 0, errors = 0;
  logic [31:0] m_rd = '0;
  logic [15:0] m_tc = '0;

  apb_rambus_bridge #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .nRst(nRst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RamBusnCs(RamBusnCs), .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch),
    .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn), .RamBusDataOut(RamBusDataOut),
    .RamBusAck(RamBusAck), .TimeoutCount(TimeoutCount)
  );

  always #5 clk = ~clk;

  // One APB transfer; d = idle REQ cycles before the ack (d >= TO means no ack at all).
  // Entered and left at 1 time unit after a rising edge, leaving the bus in the cycle after RESP.
  task automatic xfer(input logic wr, input logic [13:0] a, input logic [31:0] wd, input logic [31:0] rd, input int d);
    int   n;
    logic exp_err;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; RamBusAck = 1'($urandom);
    @(posedge clk); #1 PENABLE = 1'b1;
    n = d < TO ? d + 1 : TO;
    for (int c = 1; c <= n; c++) begin
      RamBusAck = c == d + 1;
      RamBusDataOut = c == d + 1 ? rd : $urandom;
      @(negedge clk);
      checks++;
      if ({RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, PREADY, PRDATA} !== {2'b11, wr, a, wd, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL req_phase cyc %0d: got %h exp %h", c,
          {RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, PREADY, PRDATA}, {2'b11, wr, a, wd, 1'b0, 32'h0});
      end
      @(posedge clk); #1;
    end
    if (d < TO) begin
      if (!wr) m_rd = rd;
      exp_err = 1'b0;
    end else begin
      m_rd = ERR;
      exp_err = 1'b1;
      if (m_tc != 16'hFFFF) m_tc++;
    end
    RamBusAck = 1'($urandom); RamBusDataOut = $urandom;
    @(negedge clk);
    checks++;
    if ({PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, TimeoutCount} !== {1'b1, exp_err, m_rd, 2'b00, m_tc}) begin
      errors++;
      $display("FAIL resp_phase: got %h exp %h", {PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, TimeoutCount},
        {1'b1, exp_err, m_rd, 2'b00, m_tc});
    end
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; RamBusAck = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      checks++;
      if ({PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, TimeoutCount} !== {36'h0, m_tc}) begin
        errors++;
        $display("FAIL idle: got %h exp %h", {PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, TimeoutCount}, {36'h0, m_tc});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2 nRst = 1'b0;
    #1 checks++;
    if ({PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, TimeoutCount} !== 99'h0) begin
      errors++;
      $display("FAIL reset: got %h exp 0", {PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, TimeoutCount});
    end
    repeat (2) @(posedge clk);
    #2 nRst = 1'b1;
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_write_fast;
    xfer(1'b1, 14'h0123, 32'hCAFEF00D, $urandom, 0);
    idle(2);
  endtask

  task automatic test_read_delay;
    xfer(1'b0, 14'h0040, $urandom, 32'h12345678, 5);
    idle(1);
  endtask

  task automatic test_timeout;
    xfer(1'b0, 14'($urandom), $urandom, $urandom, 1000);
    idle(1);
    xfer(1'b0, 14'($urandom), $urandom, $urandom, TO - 1);
    idle(1);
  endtask

  task automatic test_abort;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h1555; PWDATA = $urandom; RamBusAck = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    repeat (2) @(posedge clk);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    checks++;
    if ({RamBusnCs, PREADY} !== 2'b10) begin
      errors++;
      $display("FAIL abort_req3: got %b exp 10", {RamBusnCs, PREADY});
    end
    @(posedge clk); #1;
    idle(3);
    xfer(1'b1, 14'($urandom), $urandom, $urandom, 1);
    idle(1);
  endtask

  task automatic test_reset_mid;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 14'h3FFF; PWDATA = 32'hFFFF_FFFF; RamBusAck = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #3 nRst = 1'b0;
    #1 checks++;
    if ({PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, TimeoutCount} !== 99'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h exp 0", {PREADY, PSLVERR, PRDATA, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn, TimeoutCount});
    end
    m_rd = '0; m_tc = '0;
    @(posedge clk); #2 nRst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    idle(1);
    xfer(1'b1, 14'h0222, 32'h0BAD_CAFE, $urandom, 0);
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      xfer(1'($urandom), 14'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_write_fast;
    test_read_delay;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_rambus_bridge.md
APB_RAMBUS_BRIDGE -- requirements
Module: apb_rambus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum REQ-state cycles spent waiting for RamBusAck before an error response.
REQ-002 Parameter ERR_DATA, default 32'hBAD0_BAD0: PRDATA value returned on a timed-out read.
REQ-003 clk  in  1  single system clock (fabric GL0); all logic is on the rising edge.
REQ-004 nRst  in  1  asynchronous, active-low reset.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB3 slave control from the MSS fabric interface.
REQ-006 PADDR  in  14  APB byte address, bits 13:0.
REQ-007 PWDATA  in  32  APB write data.
REQ-008 PRDATA  out  32  APB read data, valid only while PREADY=1.
REQ-009 PREADY  out  1  APB transfer-complete strobe.
REQ-010 PSLVERR  out  1  APB error; valid only while PREADY=1.
REQ-011 RamBusnCs  out  1  RamBus select; driven high for the whole downstream transfer.
REQ-012 RamBusWrnRd  out  1  RamBus direction: 1 = write, 0 = read.
REQ-013 RamBusLatch  out  1  RamBus strobe.
REQ-014 RamBusAddress  out  14  registered address.
REQ-015 RamBusDataIn  out  32  registered write data.
REQ-016 RamBusDataOut  in  32  read data from DMMainPorts.
REQ-017 RamBusAck  in  1  DMMainPorts transfer acknowledge.
REQ-018 TimeoutCount  out  16  saturating count of timed-out transfers.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ and RESP.
REQ-020 In IDLE, PSEL=1 with PENABLE=0 SHALL capture PADDR, PWDATA and PWRITE into holding registers, clear the wait counter, and enter REQ on the next edge.
REQ-021 In REQ, the block SHALL drive RamBusnCs=1 and RamBusLatch=1, and hold RamBusWrnRd, RamBusAddress and RamBusDataIn from the holding registers.
REQ-022 In REQ, the wait counter SHALL increment every cycle that RamBusAck=0.
REQ-023 In REQ, RamBusAck=1 SHALL:
  - capture RamBusDataOut into the read register when RamBusWrnRd=0 (read register unchanged on writes);
  - clear the error flag;
  - enter RESP.
REQ-024 In REQ, if the wait counter reaches TIMEOUT_CYCLES with RamBusAck=0, the block SHALL:
  - load ERR_DATA into the read register;
  - set the error flag;
  - increment TimeoutCount, saturating at 16'hFFFF;
  - enter RESP.
REQ-025 If RamBusAck=1 on the same cycle the timeout is reached, the ack SHALL win (no error).
REQ-026 In RESP, the block SHALL drive PREADY=1 for exactly one cycle, PRDATA from the read register, and PSLVERR from the error flag, with RamBusnCs and RamBusLatch at 0, then return to IDLE.
REQ-027 PREADY and PSLVERR SHALL be 0 in all states other than RESP.
REQ-028 PRDATA SHALL be 0 whenever PREADY=0.
REQ-029 Minimum latency: setup at cycle T0, REQ at T1, Ack sampled at T1, PREADY=1 at T2; 3 APB cycles per transfer.
REQ-030 If PSEL falls during REQ (master abort), the block SHALL return to IDLE on the next edge without asserting PREADY, with downstream strobes deasserted and TimeoutCount unchanged.
REQ-031 RamBusAck SHALL be ignored in IDLE and RESP.
REQ-032 Back-to-back transfers: a new setup phase sampled in the cycle after RESP SHALL be accepted normally.
REQ-033 The wait counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL never wrap.

Reset
REQ-034 nRst=0 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE;
  - PREADY, PSLVERR, RamBusnCs, RamBusLatch and RamBusWrnRd to 0;
  - PRDATA, RamBusAddress, RamBusDataIn, the read register, the wait counter and TimeoutCount to 0.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer with no PREADY pulse.
REQ-036 Release of reset SHALL take effect on the first clk edge after nRst rises.

Verification
REQ-037 Write 0x0123 <= 32'hCAFEF00D, RamBusAck high in the first REQ cycle -> RamBusDataIn=32'hCAFEF00D and RamBusWrnRd=1 during REQ; PREADY=1 with PSLVERR=0 at T2.
REQ-038 Read 0x0040, RamBusAck after 5 cycles with RamBusDataOut=32'h12345678 -> PRDATA=32'h12345678 with PREADY=1 exactly one cycle later; PSLVERR=0.
REQ-039 Read with RamBusAck held low, TIMEOUT_CYCLES=255 -> PREADY=1, PSLVERR=1, PRDATA=32'hBAD0_BAD0 after 255 REQ cycles; TimeoutCount=1.
REQ-040 RamBusAck rising on the timeout cycle -> PSLVERR=0, RamBus data returned; TimeoutCount unchanged.
REQ-041 PSEL dropped on REQ cycle 3 -> IDLE next edge, RamBusnCs=0, PREADY never asserted.
REQ-042 nRst pulsed low mid-REQ -> all outputs 0 asynchronously; a following write completes normally with PREADY at T2.
